// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// The optional prescaler is enabled with the UPDOWN_CNT_PRESCALE_EN macro.
package updown_mod_counter_pkg;

  localparam logic CNT_DIR_UP = 1'b1;
  localparam logic CNT_DIR_DN = 1'b0;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of updown_mod_counter; the master drives controls, the slave
// (the counter) returns cnt, tc and wrap. No handshake: every control is sampled each edge.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             wrap;

  modport master (
    output clr, load, load_val, en, up_dn,
    input  cnt, tc, wrap
  );

  modport slave (
    input  clr, load, load_val, en, up_dn,
    output cnt, tc, wrap
  );

endinterface

// File: rtl/updown_mod_counter_cnt_prescaler.sv
// Modulo-PRESCALE enable divider: tick is high on the en cycle where the divider
// sits at its last value, after which it restarts from 0.
module cnt_prescaler
  import updown_mod_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned    PW     = cnt_clog2(PRESCALE);
  localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q;

  assign tick = en & (pcnt_q == P_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      pcnt_q <= '0;
    end else if (en) begin
      pcnt_q <= tick ? '0 : pcnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter modulo MODULUS with clear, clamped load, wrap/saturate mode,
// combinational terminal count and a registered wrap pulse (prescaler: UPDOWN_CNT_PRESCALE_EN).
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
`ifdef UPDOWN_CNT_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_mod_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic             tick;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_zero;
  logic             dir_up;

`ifdef UPDOWN_CNT_PRESCALE_EN
  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.clr | bus.load),
    .en    (bus.en),
    .tick  (tick)
  );
`else
  assign tick = bus.en;
`endif

  // Terminal compares are explicit even when MODULUS == 2**WIDTH.
  assign at_max  = (cnt_q == CNT_MAX);
  assign at_zero = (cnt_q == '0);
  assign dir_up  = (bus.up_dn == CNT_DIR_UP);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      cnt_d = '0;
    end else if (bus.load) begin
      // Out-of-range loads clamp to the top of the range so cnt is always legal.
      cnt_d = (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
    end else if (tick) begin
      if (dir_up) begin
        if (!at_max) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (SATURATE == 0) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (SATURATE == 0) begin
          cnt_d  = CNT_MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // tc is combinational so a following stage can use it directly as its en.
  assign bus.tc   = tick & (dir_up ? at_max : at_zero);
  assign bus.cnt  = cnt_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: mod-10 wrap, saturate, cascade and
// (with UPDOWN_CNT_PRESCALE_EN) the prescaled variant.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic cas_rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) u_if ();
  updown_mod_counter_if #(.WIDTH(4)) s_if ();
  updown_mod_counter_if #(.WIDTH(4)) lo_if ();
  updown_mod_counter_if #(.WIDTH(4)) hi_if ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (
    .clk(clk), .rst_n(cas_rst_n), .bus(lo_if.slave));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_hi (
    .clk(clk), .rst_n(cas_rst_n), .bus(hi_if.slave));

  assign hi_if.en = lo_if.tc;

`ifdef UPDOWN_CNT_PRESCALE_EN
  updown_mod_counter_if #(.WIDTH(4)) p_if ();
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) dut_pre (
    .clk(clk), .rst_n(rst_n), .bus(p_if.slave));
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp_v);
    checks++;
    assert (got === exp_v) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cas_rst_n = 1'b0;
    u_if.clr = 0; u_if.load = 0; u_if.load_val = 0; u_if.en = 0; u_if.up_dn = 1;
    s_if.clr = 0; s_if.load = 0; s_if.load_val = 0; s_if.en = 0; s_if.up_dn = 1;
    lo_if.clr = 0; lo_if.load = 0; lo_if.load_val = 0; lo_if.en = 0; lo_if.up_dn = 1;
    hi_if.clr = 0; hi_if.load = 0; hi_if.load_val = 0; hi_if.up_dn = 1;
`ifdef UPDOWN_CNT_PRESCALE_EN
    p_if.clr = 0; p_if.load = 0; p_if.load_val = 0; p_if.en = 0; p_if.up_dn = 1;
`endif

    // Reset
    step();
    step();
    check("rst_cnt", int'(u_if.cnt), 0);
    check("rst_wrap", int'(u_if.wrap), 0);
    check("rst_tc_idle", int'(u_if.tc), 0);
    u_if.en = 1; u_if.up_dn = 0;
    #1;
    check("rst_tc_down", int'(u_if.tc), 1);

    // Count up through the wrap
    rst_n = 1'b1;
    u_if.up_dn = 1;
    #1;
    check("up_tc_at0", int'(u_if.tc), 0);
    for (int i = 1; i <= 11; i++) begin
      step();
      check($sformatf("up_cnt_%0d", i), int'(u_if.cnt), i % 10);
      check($sformatf("up_wrap_%0d", i), int'(u_if.wrap), (i == 10) ? 1 : 0);
      check($sformatf("up_tc_%0d", i), int'(u_if.tc), (i == 9) ? 1 : 0);
    end

    // Count down from 0 through the wrap
    u_if.clr = 1;
    step();
    check("clr_cnt", int'(u_if.cnt), 0);
    u_if.clr = 0; u_if.up_dn = 0;
    #1;
    check("dn_tc_at0", int'(u_if.tc), 1);
    step();
    check("dn_cnt_9", int'(u_if.cnt), 9);
    check("dn_wrap_9", int'(u_if.wrap), 1);
    check("dn_tc_9", int'(u_if.tc), 0);
    step();
    check("dn_cnt_8", int'(u_if.cnt), 8);
    check("dn_wrap_8", int'(u_if.wrap), 0);
    step();
    check("dn_cnt_7", int'(u_if.cnt), 7);

    // Load clamping and priorities
    u_if.up_dn = 1; u_if.load = 1; u_if.load_val = 4'd13;
    step();
    check("load_clamp13", int'(u_if.cnt), 9);
    check("load_wrap", int'(u_if.wrap), 0);
    check("load_tc", int'(u_if.tc), 1);
    u_if.clr = 1; u_if.load_val = 4'd5;
    step();
    check("clr_beats_load", int'(u_if.cnt), 0);
    u_if.clr = 0; u_if.load_val = 4'd6;
    step();
    check("load_6", int'(u_if.cnt), 6);
    u_if.load_val = 4'd9;
    step();
    check("load_9", int'(u_if.cnt), 9);
    u_if.load_val = 4'd15;
    step();
    check("load_clamp15", int'(u_if.cnt), 9);
    u_if.load = 0; u_if.en = 0;
    step();
    check("hold_cnt", int'(u_if.cnt), 9);
    check("hold_tc", int'(u_if.tc), 0);
    check("hold_wrap", int'(u_if.wrap), 0);

    // Saturate mode
    s_if.load = 1; s_if.load_val = 4'd7;
    step();
    check("sat_load7", int'(s_if.cnt), 7);
    s_if.load = 0; s_if.en = 1; s_if.up_dn = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("sat_cnt_%0d", i), int'(s_if.cnt), (i == 1) ? 8 : 9);
      check($sformatf("sat_wrap_%0d", i), int'(s_if.wrap), 0);
      check($sformatf("sat_tc_%0d", i), int'(s_if.tc), (i == 1) ? 0 : 1);
    end
    s_if.up_dn = 0;
    step();
    check("sat_dirchg", int'(s_if.cnt), 8);
    s_if.clr = 1;
    step();
    s_if.clr = 0;
    #1;
    check("sat_tc_low", int'(s_if.tc), 1);
    step();
    check("sat_hold0", int'(s_if.cnt), 0);
    check("sat_hold0_wrap", int'(s_if.wrap), 0);

    // Cascaded decimal digits
    cas_rst_n = 1'b1;
    lo_if.en = 1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 10) begin
        check("cas_lo_wrap10", int'(lo_if.wrap), 1);
        check("cas_hi_10", int'(hi_if.cnt), 1);
      end
    end
    check("cas_lo_25", int'(lo_if.cnt), 5);
    check("cas_hi_25", int'(hi_if.cnt), 2);
    step();
    step();
    step();
    cas_rst_n = 1'b0;
    step();
    check("cas_rst_lo", int'(lo_if.cnt), 0);
    check("cas_rst_hi", int'(hi_if.cnt), 0);
    cas_rst_n = 1'b1;

`ifdef UPDOWN_CNT_PRESCALE_EN
    // Prescaled counting and clr restarting the period
    p_if.en = 1; p_if.up_dn = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("pre_cnt_%0d", i), int'(p_if.cnt), i / 3);
    end
    step();
    p_if.clr = 1;
    step();
    check("pre_clr", int'(p_if.cnt), 0);
    p_if.clr = 0;
    step();
    step();
    check("pre_restart_2", int'(p_if.cnt), 0);
    step();
    check("pre_restart_3", int'(p_if.cnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
